// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the 7-seg scan controller.
// Segment order {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } cv_state_t;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one shift per cycle, DW cycles,
// then a one-cycle Done pulse with the BCD result on Bcd.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DW   = 5,
  parameter int NDIG = 2
) (
  input  logic              Clo,
  input  logic              Rst,
  input  logic [DW-1:0]     D,
  input  logic              D_vld,
  output logic              D_rdy,
  output logic              Done,
  output logic [4*NDIG-1:0] Bcd
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(DW + 1);

  cv_state_t     r_state;
  logic [DW-1:0] r_bin;
  logic [BW-1:0] r_bcd;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clo) begin
    if (Rst) begin
      r_state <= CV_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CV_IDLE: begin
          if (D_vld) begin
            r_bin   <= D;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          r_bcd <= {w_adj[BW-2:0], r_bin[DW-1]};
          r_bin <= {r_bin[DW-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DW - 1))
            r_state <= CV_DONE;
        end
        CV_DONE: r_state <= CV_IDLE;
        default: r_state <= CV_IDLE;
      endcase
    end
  end

  assign D_rdy = (r_state == CV_IDLE);
  assign Done  = (r_state == CV_DONE);
  assign Bcd   = r_bcd;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scan controller with serial BCD conversion.
// Define LZ_BLANK_EN to suppress leading zeros on digits above units.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DW        = 5,
  parameter int NDIG      = 2,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic            Clo,
  input  logic            Rst,
  input  logic [DW-1:0]   D,
  input  logic            D_vld,
  output logic            D_rdy,
  output logic            Busy,
  output logic [NDIG-1:0] An,
  output logic [6:0]      Seg
);

  localparam int BW = 4 * NDIG;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic            w_rdy;
  logic            w_done;
  logic [BW-1:0]   w_bcd;
  logic [BW-1:0]   r_shadow;
  logic [BW-1:0]   r_act;
  logic [PW-1:0]   r_pre;
  logic [IW-1:0]   r_idx;
  logic [NDIG-1:0] r_an;
  logic [6:0]      r_seg;
  logic [BW-1:0]   w_cur;
  logic [3:0]      w_nib;
  logic            w_lz;
  logic            w_blank;

  bin2bcd_seq #(.DW(DW), .NDIG(NDIG)) u_conv (
    .Clo   (Clo),
    .Rst   (Rst),
    .D     (D),
    .D_vld (D_vld),
    .D_rdy (w_rdy),
    .Done  (w_done),
    .Bcd   (w_bcd)
  );

  // At a slot boundary the active value is being reloaded this edge
  assign w_cur = (r_pre == '0) ? r_shadow : r_act;
  assign w_nib = w_cur[4*r_idx +: 4];

`ifdef LZ_BLANK_EN
  assign w_lz = (r_idx != '0) && ((w_cur >> (4 * r_idx)) == '0);
`else
  assign w_lz = 1'b0;
`endif

  assign w_blank = (r_pre < PW'(BLANK_CYC)) || w_lz;

  always_ff @(posedge Clo) begin
    if (Rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_act    <= '0;
      r_an     <= '1;
      r_seg    <= SEG_OFF;
    end else begin
      if (r_pre == PW'(SCAN_DIV - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (r_pre == '0)
        r_act <= r_shadow;
      if (w_done)
        r_shadow <= w_bcd;
      r_an  <= w_blank ? '1 : ~(NDIG'(1) << r_idx);
      r_seg <= w_blank ? SEG_OFF : seg_decode(w_nib);
    end
  end

  assign D_rdy = w_rdy;
  assign Busy  = ~w_rdy;
  assign An    = r_an;
  assign Seg   = r_seg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: vector table, directed corner sequences,
// random traffic against an arithmetic display model.
module tb_seg7_scan_ctrl;

  localparam int DW = 5;
  localparam int NDIG = 2;
  localparam int SD = 8;
  localparam int BC = 2;

  logic       Clo = 1'b0;
  logic       Rst = 1'b1;
  logic [4:0] D = '0;
  logic       D_vld = 1'b0;
  logic       D_rdy;
  logic       Busy;
  logic [1:0] An;
  logic [6:0] Seg;

  seg7_scan_ctrl #(
    .DW(DW), .NDIG(NDIG), .SCAN_DIV(SD), .BLANK_CYC(BC)
  ) dut (
    .Clo(Clo), .Rst(Rst), .D(D), .D_vld(D_vld),
    .D_rdy(D_rdy), .Busy(Busy), .An(An), .Seg(Seg)
  );

  always #5 Clo = ~Clo;

  int n_chk = 0;
  int n_fail = 0;

  int m_s, m_cnt, m_pend, m_shadow, m_active;
  bit m_acc;
  logic [1:0] e_an;
  logic [6:0] e_seg;

  typedef struct {
    bit         rst;
    logic [1:0] an;
    logic [6:0] seg;
    bit         rdy;
  } vec_t;
  vec_t tv[7];

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] t[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[n];
  endfunction

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected display after the coming edge, from slot arithmetic
  task automatic model_edge();
    int pre, idx, val, dig;
    bit blank;
    m_acc = 0;
    if (Rst) begin
      m_s = 0; m_cnt = 0; m_shadow = 0; m_active = 0;
      e_an = 2'b11; e_seg = 7'h7F;
    end else begin
      pre = m_s % SD;
      idx = (m_s / SD) % NDIG;
      if (pre == 0) m_active = m_shadow;
      val = m_active;
      dig = (val / pow10(idx)) % 10;
      blank = (pre < BC);
`ifdef LZ_BLANK_EN
      if (idx > 0 && val < pow10(idx)) blank = 1;
`endif
      e_an = blank ? 2'b11 : (2'b11 & ~(2'b01 << idx));
      e_seg = blank ? 7'h7F : seg_of(dig);
      if (m_cnt == 0) begin
        if (D_vld) begin
          m_cnt = DW + 1; m_pend = int'(D); m_acc = 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_shadow = m_pend;
      end
      m_s++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clo);
    #1;
    check("an", 32'(An), 32'(e_an));
    check("seg", 32'(Seg), 32'(e_seg));
    check("rdy", 32'(D_rdy), 32'(m_cnt == 0));
    check("busy", 32'(Busy), 32'(m_cnt != 0));
  endtask

  task automatic offer(input int v, output bit ok);
    ok = 0;
    D = 5'(v);
    D_vld = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = m_acc;
    end
  endtask

  initial begin
    bit ok, seen_a, seen_b, bad;
    int lows, waitc;

    tv[0] = '{1, 2'b11, 7'h7F, 1};
    tv[1] = '{1, 2'b11, 7'h7F, 1};
    tv[2] = '{1, 2'b11, 7'h7F, 1};
    tv[3] = '{0, 2'b11, 7'h7F, 1};
    tv[4] = '{0, 2'b11, 7'h7F, 1};
    tv[5] = '{0, 2'b10, 7'h40, 1};
    tv[6] = '{0, 2'b10, 7'h40, 1};

    for (int i = 0; i < 7; i++) begin
      Rst = tv[i].rst;
      tick();
      check("tv_an", 32'(An), 32'(tv[i].an));
      check("tv_seg", 32'(Seg), 32'(tv[i].seg));
      check("tv_rdy", 32'(D_rdy), 32'(tv[i].rdy));
    end

    // D=31: ready low for six sampled cycles, then 3 / 1 shown
    offer(31, ok);
    check("acc31", 32'(ok), 32'd1);
    D_vld = 0;
    lows = (D_rdy == 1'b0) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (D_rdy == 1'b0) lows++;
      else break;
    end
    check("rdy_low_len", 32'(lows), 32'd6);
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 3 * SD * NDIG; i++) begin
      tick();
      if (An == 2'b01 && Seg == 7'h30) seen_a = 1;
      if (An == 2'b10 && Seg == 7'h79) seen_b = 1;
    end
    check("show31_d1", 32'(seen_a), 32'd1);
    check("show31_d0", 32'(seen_b), 32'd1);

    // 12 offered while 9 converts
    offer(9, ok);
    check("acc9", 32'(ok), 32'd1);
    waitc = 0;
    D = 5'd12;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      waitc++;
      ok = m_acc;
    end
    check("acc12", 32'(ok), 32'd1);
    check("acc12_wait", 32'(waitc), 32'd7);
    D_vld = 0;
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 3 * SD * NDIG; i++) begin
      tick();
      if (An == 2'b01 && Seg == 7'h79) seen_a = 1;
      if (An == 2'b10 && Seg == 7'h24) seen_b = 1;
    end
    check("show12_d1", 32'(seen_a), 32'd1);
    check("show12_d0", 32'(seen_b), 32'd1);

    // Reset at shift step 3 of D=25
    Rst = 1; tick(); Rst = 0;
    offer(25, ok);
    D_vld = 0;
    tick(); tick();
    Rst = 1; tick(); Rst = 0;
    check("rst_rdy", 32'(D_rdy), 32'd1);
    bad = 0; seen_b = 0;
    for (int i = 0; i < 3 * SD * NDIG; i++) begin
      tick();
      if (Seg == 7'h12 || Seg == 7'h24) bad = 1;
      if (An == 2'b10 && Seg == 7'h40) seen_b = 1;
    end
    check("never25", 32'(bad), 32'd0);
    check("zero_shown", 32'(seen_b), 32'd1);

    // D=7: leading digit blanked or shown as 0
    offer(7, ok);
    D_vld = 0;
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 4 * SD * NDIG; i++) begin
      tick();
      if (An == 2'b01 && Seg == 7'h40) seen_a = 1;
      if (An == 2'b10 && Seg == 7'h78) seen_b = 1;
    end
`ifdef LZ_BLANK_EN
    check("lz_d1", 32'(seen_a), 32'd0);
`else
    check("lz_d1", 32'(seen_a), 32'd1);
`endif
    check("d0_7", 32'(seen_b), 32'd1);

    // Random requester honouring hold-until-accepted
    for (int i = 0; i < 600; i++) begin
      if (!D_vld || m_acc) begin
        D_vld = ($urandom_range(0, 3) == 0);
        D = 5'($urandom_range(0, 31));
      end
      Rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    Rst = 0;
    D_vld = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
